// File: rtl/isp_pkg.sv
// Shared definitions for the raw-domain ISP blocks: CFA phase codes and gain fixed-point format.
package isp_pkg;

   typedef enum logic [1:0] {
      CFA_R  = 2'd0,
      CFA_GR = 2'd1,
      CFA_GB = 2'd2,
      CFA_B  = 2'd3
   } cfa_e;

   localparam int GAIN_ONE  = 256;
   localparam int GAIN_FRAC = 8;

endpackage

// File: rtl/isp_wb_stats.sv
// Per-frame R/G/B sums of the corrected stream; latches and pulses at each output frame start.
module isp_wb_stats
   import isp_pkg::*;
#(
   parameter int BITS   = 16,
   parameter int STAT_W = 40
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic [BITS-1:0]   pix,
   input  cfa_e              ch,
   input  logic              de,
   input  logic              vsync,
   output logic [STAT_W-1:0] stat_r,
   output logic [STAT_W-1:0] stat_g,
   output logic [STAT_W-1:0] stat_b,
   output logic              stat_valid
);

   logic              vsync_q;
   logic              frame_start;
   logic [STAT_W-1:0] acc_r, acc_g, acc_b;
   logic [STAT_W-1:0] base_r, base_g, base_b;
   logic [STAT_W-1:0] nxt_r, nxt_g, nxt_b;

   function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                 input logic [BITS-1:0]   b);
      logic [STAT_W:0] s;
      s = {1'b0, a} + {{(STAT_W + 1 - BITS){1'b0}}, b};
      return s[STAT_W] ? {STAT_W{1'b1}} : s[STAT_W-1:0];
   endfunction

   assign frame_start = vsync & ~vsync_q;

   // A pixel coinciding with the frame edge belongs to the new frame.
   always_comb begin
      base_r = frame_start ? '0 : acc_r;
      base_g = frame_start ? '0 : acc_g;
      base_b = frame_start ? '0 : acc_b;
      nxt_r  = base_r;
      nxt_g  = base_g;
      nxt_b  = base_b;
      if (de) begin
         case (ch)
            CFA_R:          nxt_r = sat_add(base_r, pix);
            CFA_GR, CFA_GB: nxt_g = sat_add(base_g, pix);
            CFA_B:          nxt_b = sat_add(base_b, pix);
            default:        nxt_r = base_r;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q    <= 1'b0;
         acc_r      <= '0;
         acc_g      <= '0;
         acc_b      <= '0;
         stat_r     <= '0;
         stat_g     <= '0;
         stat_b     <= '0;
         stat_valid <= 1'b0;
      end else begin
         vsync_q    <= vsync;
         acc_r      <= nxt_r;
         acc_g      <= nxt_g;
         acc_b      <= nxt_b;
         stat_valid <= frame_start;
         if (frame_start) begin
            stat_r <= acc_r;
            stat_g <= acc_g;
            stat_b <= acc_b;
         end
      end
   end

endmodule

// File: rtl/isp_wb_gain.sv
// Black-level subtract and per-CFA white-balance gain ahead of the debayer, with frame-synchronous
// shadow configuration and per-frame channel statistics.
module isp_wb_gain
   import isp_pkg::*;
#(
   parameter int BITS   = 16,
   parameter int BAYER  = 0,
   parameter int GAIN_W = 12,
   parameter int STAT_W = 40
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic [BITS-1:0]   in_raw,
   input  logic              in_href,
   input  logic              in_vsync,
   input  logic              in_de,
   input  logic [GAIN_W-1:0] cfg_r_gain,
   input  logic [GAIN_W-1:0] cfg_gr_gain,
   input  logic [GAIN_W-1:0] cfg_gb_gain,
   input  logic [GAIN_W-1:0] cfg_b_gain,
   input  logic [BITS-1:0]   cfg_blc,
   input  logic              cfg_bypass,
   input  logic              cfg_update,
   output logic [BITS-1:0]   out_raw,
   output logic              out_href,
   output logic              out_vsync,
   output logic              out_de,
   output logic [STAT_W-1:0] stat_r,
   output logic [STAT_W-1:0] stat_g,
   output logic [STAT_W-1:0] stat_b,
   output logic              stat_valid
);

   localparam int           PW        = BITS + GAIN_W;
   localparam logic [1:0]   BAYER_PH  = 2'(BAYER);
   localparam logic [PW:0]  RND_HALF  = (PW + 1)'(2 ** (GAIN_FRAC - 1));
   localparam logic [PW:0]  PIX_MAX   = {{(PW + 1 - BITS){1'b0}}, {BITS{1'b1}}};

   logic [3:0]        href_dly, vsync_dly, de_dly;
   logic              vs_rise, href_fall;
   logic              pix_par, line_par;
   cfa_e              in_ch;

   logic [GAIN_W-1:0] act_r_gain, act_gr_gain, act_gb_gain, act_b_gain;
   logic [BITS-1:0]   act_blc;
   logic              act_bypass, pending;

   logic [BITS-1:0]   s1_pix, s2_raw, s3_raw;
   logic [BITS-1:0]   s2_d;
   logic [GAIN_W-1:0] s2_gain, sel_gain;
   logic [PW-1:0]     s3_p;
   logic              s1_byp, s2_byp, s3_byp;
   cfa_e              s1_ch, s2_ch, s3_ch, s4_ch;
   logic [PW:0]       rnd, scaled;
   logic [BITS-1:0]   sat_val;

   assign vs_rise   = in_vsync & ~vsync_dly[0];
   assign href_fall = href_dly[0] & ~in_href;
   assign in_ch     = cfa_e'({line_par, pix_par} ^ BAYER_PH);

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         href_dly  <= '0;
         vsync_dly <= '0;
         de_dly    <= '0;
         pix_par   <= 1'b0;
         line_par  <= 1'b0;
      end else begin
         href_dly  <= {href_dly[2:0], in_href};
         vsync_dly <= {vsync_dly[2:0], in_vsync};
         de_dly    <= {de_dly[2:0], in_de};
         pix_par   <= in_href ? ~pix_par : 1'b0;
         if (in_vsync)
            line_par <= 1'b0;
         else if (href_fall)
            line_par <= ~line_par;
      end
   end

   // Shadow registers only move on a frame start so a frame never sees mixed settings.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         act_r_gain  <= GAIN_W'(GAIN_ONE);
         act_gr_gain <= GAIN_W'(GAIN_ONE);
         act_gb_gain <= GAIN_W'(GAIN_ONE);
         act_b_gain  <= GAIN_W'(GAIN_ONE);
         act_blc     <= '0;
         act_bypass  <= 1'b0;
         pending     <= 1'b0;
      end else if (vs_rise && (pending || cfg_update)) begin
         act_r_gain  <= cfg_r_gain;
         act_gr_gain <= cfg_gr_gain;
         act_gb_gain <= cfg_gb_gain;
         act_b_gain  <= cfg_b_gain;
         act_blc     <= cfg_blc;
         act_bypass  <= cfg_bypass;
         pending     <= 1'b0;
      end else if (cfg_update) begin
         pending     <= 1'b1;
      end
   end

   always_comb begin
      sel_gain = act_r_gain;
      case (s1_ch)
         CFA_R:   sel_gain = act_r_gain;
         CFA_GR:  sel_gain = act_gr_gain;
         CFA_GB:  sel_gain = act_gb_gain;
         CFA_B:   sel_gain = act_b_gain;
         default: sel_gain = act_r_gain;
      endcase
   end

   always_comb begin
      rnd     = {1'b0, s3_p} + RND_HALF;
      scaled  = rnd >> GAIN_FRAC;
      sat_val = (scaled > PIX_MAX) ? {BITS{1'b1}} : scaled[BITS-1:0];
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         s1_pix  <= '0;
         s1_ch   <= CFA_R;
         s1_byp  <= 1'b0;
         s2_d    <= '0;
         s2_gain <= '0;
         s2_raw  <= '0;
         s2_ch   <= CFA_R;
         s2_byp  <= 1'b0;
         s3_p    <= '0;
         s3_raw  <= '0;
         s3_ch   <= CFA_R;
         s3_byp  <= 1'b0;
         out_raw <= '0;
         s4_ch   <= CFA_R;
      end else begin
         s1_pix  <= in_raw;
         s1_ch   <= in_ch;
         s1_byp  <= act_bypass;

         s2_d    <= (s1_pix > act_blc) ? (s1_pix - act_blc) : '0;
         s2_gain <= sel_gain;
         s2_raw  <= s1_pix;
         s2_ch   <= s1_ch;
         s2_byp  <= s1_byp;

         s3_p    <= PW'(s2_d) * PW'(s2_gain);
         s3_raw  <= s2_raw;
         s3_ch   <= s2_ch;
         s3_byp  <= s2_byp;

         out_raw <= s3_byp ? s3_raw : sat_val;
         s4_ch   <= s3_ch;
      end
   end

   assign out_href  = href_dly[3];
   assign out_vsync = vsync_dly[3];
   assign out_de    = de_dly[3];

   isp_wb_stats #(
      .BITS   (BITS),
      .STAT_W (STAT_W)
   ) u_stats (
      .pclk       (pclk),
      .rst_n      (rst_n),
      .pix        (out_raw),
      .ch         (s4_ch),
      .de         (de_dly[3]),
      .vsync      (vsync_dly[3]),
      .stat_r     (stat_r),
      .stat_g     (stat_g),
      .stat_b     (stat_b),
      .stat_valid (stat_valid)
   );

endmodule

// File: tb/tb_isp_wb_gain.sv
// Directed bench for isp_wb_gain: expected pixels and frame sums queued at drive time, checked at output.
module tb_isp_wb_gain;

   localparam int BITS   = 16;
   localparam int GAIN_W = 12;
   localparam int STAT_W = 40;

   logic              pclk = 1'b0;
   logic              rst_n;
   logic [BITS-1:0]   in_raw;
   logic              in_href, in_vsync, in_de;
   logic [GAIN_W-1:0] cfg_r_gain, cfg_gr_gain, cfg_gb_gain, cfg_b_gain;
   logic [BITS-1:0]   cfg_blc;
   logic              cfg_bypass, cfg_update;
   logic [BITS-1:0]   out_raw;
   logic              out_href, out_vsync, out_de;
   logic [STAT_W-1:0] stat_r, stat_g, stat_b;
   logic              stat_valid;

   always #5 pclk = ~pclk;

   isp_wb_gain #(.BITS(BITS), .BAYER(0), .GAIN_W(GAIN_W), .STAT_W(STAT_W)) dut (
      .pclk(pclk), .rst_n(rst_n), .in_raw(in_raw), .in_href(in_href), .in_vsync(in_vsync),
      .in_de(in_de), .cfg_r_gain(cfg_r_gain), .cfg_gr_gain(cfg_gr_gain),
      .cfg_gb_gain(cfg_gb_gain), .cfg_b_gain(cfg_b_gain), .cfg_blc(cfg_blc),
      .cfg_bypass(cfg_bypass), .cfg_update(cfg_update), .out_raw(out_raw),
      .out_href(out_href), .out_vsync(out_vsync), .out_de(out_de), .stat_r(stat_r),
      .stat_g(stat_g), .stat_b(stat_b), .stat_valid(stat_valid)
   );

   typedef struct {int v; int cyc;} exp_t;
   typedef struct {longint r; longint g; longint b;} st_t;

   exp_t       exp_q[$];
   st_t        stat_q[$];
   logic [2:0] fr_q[$];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         e_gain[4];
   int         e_blc;
   bit         e_byp;
   longint     cur[4];
   bit         prev_sv;

   task automatic chk(input string tag, input longint o, input longint e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
      end
   endtask

   function automatic int model(input int pix, input int ch);
      int     d;
      longint r;
      if (e_byp) return pix;
      d = (pix > e_blc) ? pix - e_blc : 0;
      r = (longint'(d) * e_gain[ch] + 128) >>> 8;
      return (r > 65535) ? 65535 : int'(r);
   endfunction

   task automatic set_exp(input int r, input int gr, input int gb, input int b,
                          input int blc, input bit byp);
      e_gain[0] = r; e_gain[1] = gr; e_gain[2] = gb; e_gain[3] = b;
      e_blc = blc; e_byp = byp;
   endtask

   task automatic monitor();
      exp_t e;
      st_t  s;
      chk("framing", {out_href, out_vsync, out_de}, fr_q[0]);
      void'(fr_q.pop_front());
      if (out_href && out_de) begin
         chk("pix_expected", longint'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pix_data", out_raw, e.v);
            chk("latency", cyc - e.cyc, 4);
         end
      end
      if (stat_valid) begin
         chk("stat_pulse_width", prev_sv, 0);
         chk("stat_expected", longint'(stat_q.size() > 0), 1);
         if (stat_q.size() > 0) begin
            s = stat_q.pop_front();
            chk("stat_r", stat_r, s.r);
            chk("stat_g", stat_g, s.g);
            chk("stat_b", stat_b, s.b);
         end
      end
      prev_sv = stat_valid;
   endtask

   task automatic step(input int raw, input bit href, input bit vs, input bit de, input bit upd);
      @(negedge pclk);
      cyc++;
      monitor();
      in_raw     = raw[BITS-1:0];
      in_href    = href;
      in_vsync   = vs;
      in_de      = de;
      cfg_update = upd;
      fr_q.push_back({href, vs, de});
   endtask

   task automatic pix_step(input int x, input int y, input int pix, input bit upd);
      int ch;
      int v;
      ch = ((y % 2) * 2) + (x % 2);
      step(pix, 1'b1, 1'b0, 1'b1, upd);
      v = model(pix, ch);
      exp_q.push_back('{v, cyc});
      cur[ch] += v;
   endtask

   task automatic frame(input int w, input int h, input int base, input int stp,
                        input bit upd_vs, input bit upd_mid);
      step(0, 0, 1, 0, upd_vs);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++)
            pix_step(x, y, base + stp * (y * w + x), upd_mid && y == 0 && x == 1);
         step(0, 0, 0, 0, 0);
         step(0, 0, 0, 0, 0);
      end
      stat_q.push_back('{cur[0], cur[1] + cur[2], cur[3]});
      cur = '{0, 0, 0, 0};
   endtask

   task automatic stage(input int r, input int gr, input int gb, input int b,
                        input int blc, input bit byp);
      cfg_r_gain = GAIN_W'(r); cfg_gr_gain = GAIN_W'(gr);
      cfg_gb_gain = GAIN_W'(gb); cfg_b_gain = GAIN_W'(b);
      cfg_blc = BITS'(blc); cfg_bypass = byp;
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
   endtask

   task automatic reset_model();
      fr_q = '{3'b000, 3'b000, 3'b000, 3'b000};
      exp_q.delete();
      stat_q.delete();
      stat_q.push_back('{0, 0, 0});
      cur = '{0, 0, 0, 0};
      prev_sv = 1'b0;
      set_exp(256, 256, 256, 256, 0, 1'b0);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_out_raw"}, out_raw, 0);
      chk({tag, "_sync"}, {out_href, out_vsync, out_de}, 0);
      chk({tag, "_stats"}, stat_r | stat_g | stat_b, 0);
      chk({tag, "_stat_valid"}, stat_valid, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      in_raw = '0; in_href = 1'b0; in_vsync = 1'b0; in_de = 1'b0;
      cfg_r_gain = '0; cfg_gr_gain = '0; cfg_gb_gain = '0; cfg_b_gain = '0;
      cfg_blc = '0; cfg_bypass = 1'b0; cfg_update = 1'b0;
      reset_model();
      repeat (3) step(0, 0, 0, 0, 0);
      chk_zero_outputs("reset");
      #2 rst_n = 1'b1;
      repeat (2) step(0, 0, 0, 0, 0);
      chk_zero_outputs("post_reset");

      // 1: reset gains are unity, ramp passes unchanged with 4-cycle latency
      frame(960, 2, 0, 1, 1'b0, 1'b0);

      // 2: black level 64 clamps 40 to 0, 1064 -> 1000
      stage(256, 256, 256, 256, 64, 1'b0);
      set_exp(256, 256, 256, 256, 64, 1'b0);
      frame(2, 1, 40, 1024, 1'b0, 1'b0);

      // 3: RGGB gains on flat 1000
      stage(512, 256, 256, 384, 0, 1'b0);
      set_exp(512, 256, 256, 384, 0, 1'b0);
      frame(4, 2, 1000, 0, 1'b0, 1'b0);

      // 4: saturation at max gain, zero gain
      stage(4095, 0, 4095, 0, 0, 1'b0);
      set_exp(4095, 0, 4095, 0, 0, 1'b0);
      frame(2, 2, 65535, 0, 1'b0, 1'b0);

      // bypass ignores gains
      stage(512, 1000, 77, 4095, 300, 1'b1);
      set_exp(512, 1000, 77, 4095, 300, 1'b1);
      frame(4, 2, 5000, 7, 1'b0, 1'b0);

      // 5: mid-frame update waits for next frame; update on vsync edge applies immediately
      stage(256, 256, 256, 256, 0, 1'b0);
      set_exp(256, 256, 256, 256, 0, 1'b0);
      frame(4, 2, 1000, 0, 1'b0, 1'b0);
      cfg_r_gain = 12'd512;
      frame(4, 2, 1000, 0, 1'b0, 1'b1);
      set_exp(512, 256, 256, 256, 0, 1'b0);
      frame(4, 2, 1000, 0, 1'b0, 1'b0);
      cfg_r_gain = 12'd768;
      set_exp(768, 256, 256, 256, 0, 1'b0);
      frame(4, 2, 1000, 0, 1'b1, 1'b0);

      // 6: 2x2 flat 100 sums to 100/200/100 at the next frame start
      stage(256, 256, 256, 256, 0, 1'b0);
      set_exp(256, 256, 256, 256, 0, 1'b0);
      frame(2, 2, 100, 0, 1'b0, 1'b0);
      frame(2, 2, 200, 0, 1'b0, 1'b0);

      // async reset in the middle of a line
      stage(512, 512, 512, 512, 0, 1'b0);
      set_exp(512, 512, 512, 512, 0, 1'b0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      for (int x = 0; x < 6; x++) pix_step(x, 0, 100 + x, 1'b0);
      #3 rst_n = 1'b0;
      in_raw = '0; in_href = 1'b0; in_vsync = 1'b0; in_de = 1'b0;
      #1 chk_zero_outputs("mid_reset");
      reset_model();
      repeat (3) step(0, 0, 0, 0, 0);
      #2 rst_n = 1'b1;
      step(0, 0, 0, 0, 0);
      frame(2, 2, 100, 0, 1'b0, 1'b0);
      frame(4, 2, 300, 5, 1'b0, 1'b0);

      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      repeat (10) step(0, 0, 0, 0, 0);
      chk("exp_q_drained", exp_q.size(), 0);
      chk("stat_q_drained", stat_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
